// File: rtl/pe_pkg.sv
// Shared definitions for the PE row scheduler: default operand width, row length
// and the scheduler state encoding.
package pe_pkg;

    localparam int PE_IN_WORD_SIZE = 32;
    localparam int PE_NUM_PE       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/pe_row_sched_if.sv
// Operand streams into the scheduler and the operand/clear bus it drives into the
// first PE of the row.
interface pe_row_sched_if
    import pe_pkg::*;
#(
    parameter int IN_WORD_SIZE = PE_IN_WORD_SIZE
);

    logic                    imap_valid;
    logic [IN_WORD_SIZE-1:0] imap_data;
    logic                    imap_ready;
    logic                    fmap_valid;
    logic [IN_WORD_SIZE-1:0] fmap_data;
    logic                    fmap_ready;
    logic                    pe_rst;
    logic [IN_WORD_SIZE-1:0] pe_imap;
    logic [IN_WORD_SIZE-1:0] pe_fmap;

    // master: operand sources and PE row; slave: the scheduler
    modport master (
        output imap_valid, imap_data, fmap_valid, fmap_data,
        input  imap_ready, fmap_ready, pe_rst, pe_imap, pe_fmap
    );

    modport slave (
        input  imap_valid, imap_data, fmap_valid, fmap_data,
        output imap_ready, fmap_ready, pe_rst, pe_imap, pe_fmap
    );

endinterface

// File: rtl/pe_row_sched.sv
// Sequences one accumulation job through a chained PE row: clear, feed paired
// operand beats, flush the row pipeline, then pulse done.
module pe_row_sched
    import pe_pkg::*;
#(
    parameter int IN_WORD_SIZE = PE_IN_WORD_SIZE,
    parameter int NUM_PE       = PE_NUM_PE,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    pe_row_sched_if.slave    bus,
    output logic             busy,
    output logic             done
);

    localparam int                      FL_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [FL_W-1:0]         FL_LAST   = FL_W'(NUM_PE - 1);
    localparam logic [IN_WORD_SIZE-1:0] ZERO_WORD = '0;

    sched_state_t     r_state;
    sched_state_t     w_nextState;
    logic [CNT_W-1:0] r_beatCnt;
    logic [FL_W-1:0]  r_flushCnt;
    logic             w_fire;
    logic             w_lastBeat;
    logic             w_lastFlush;

    assign w_fire      = (r_state == ST_FEED) && bus.imap_valid && bus.fmap_valid;
    assign w_lastBeat  = w_fire && (r_beatCnt == CNT_W'(1));
    assign w_lastFlush = (r_state == ST_FLUSH) && (r_flushCnt == FL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Flush counter runs only in FLUSH and returns to zero as it leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beatCnt  <= '0;
            r_flushCnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_beatCnt <= len;
            end else if (w_fire) begin
                r_beatCnt <= r_beatCnt - CNT_W'(1);
            end
            if (r_state == ST_FLUSH) begin
                r_flushCnt <= w_lastFlush ? '0 : r_flushCnt + FL_W'(1);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_nextState = ST_CLEAR;
            ST_CLEAR: w_nextState = (r_beatCnt != '0) ? ST_FEED : ST_FLUSH;
            ST_FEED:  if (w_lastBeat) w_nextState = ST_FLUSH;
            ST_FLUSH: if (w_lastFlush) w_nextState = ST_DONE;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Zero operands on idle cycles make the PEs accumulate a zero product
    assign bus.imap_ready = w_fire;
    assign bus.fmap_ready = w_fire;
    assign bus.pe_rst     = (r_state == ST_CLEAR);
    assign bus.pe_imap    = w_fire ? bus.imap_data : ZERO_WORD;
    assign bus.pe_fmap    = w_fire ? bus.fmap_data : ZERO_WORD;
    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);

endmodule

// File: tb/tb_pe_row_sched.sv
// Directed bench for pe_row_sched with a behavioural 4-PE complex MAC row
// fed from the scheduler's operand outputs.
module tb_pe_row_sched;
    import pe_pkg::*;

    localparam int W   = 32;
    localparam int NPE = 4;
    localparam int CW  = 16;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] len   = '0;
    logic          busy;
    logic          done;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;
    int doneBase    = 0;

    pe_row_sched_if #(.IN_WORD_SIZE(W)) bus ();

    pe_row_sched #(
        .IN_WORD_SIZE(W),
        .NUM_PE(NPE),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .bus(bus.slave),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cmulRe(input logic [31:0] a, input logic [31:0] b);
        int ar, ai, br, bi;
        ar = int'($signed(a[15:0]));
        ai = int'($signed(a[31:16]));
        br = int'($signed(b[15:0]));
        bi = int'($signed(b[31:16]));
        return 16'(ar * br - ai * bi);
    endfunction

    function automatic logic [15:0] cmulIm(input logic [31:0] a, input logic [31:0] b);
        int ar, ai, br, bi;
        ar = int'($signed(a[15:0]));
        ai = int'($signed(a[31:16]));
        br = int'($signed(b[15:0]));
        bi = int'($signed(b[31:16]));
        return 16'(ar * bi + ai * br);
    endfunction

    // Each PE accumulates its operand product and forwards the operands one cycle later
    logic [W-1:0]  pipeI [NPE];
    logic [W-1:0]  pipeF [NPE];
    logic [15:0]   accRe [NPE];
    logic [15:0]   accIm [NPE];

    always @(posedge clk) begin : peRowModel
        logic [W-1:0] vI [NPE];
        logic [W-1:0] vF [NPE];
        vI[0] = bus.pe_imap;
        vF[0] = bus.pe_fmap;
        for (int k = 1; k < NPE; k++) begin
            vI[k] = pipeI[k-1];
            vF[k] = pipeF[k-1];
        end
        for (int k = 0; k < NPE; k++) begin
            if (bus.pe_rst) begin
                accRe[k] <= '0;
                accIm[k] <= '0;
                pipeI[k] <= '0;
                pipeF[k] <= '0;
            end else begin
                accRe[k] <= accRe[k] + cmulRe(vI[k], vF[k]);
                accIm[k] <= accIm[k] + cmulIm(vI[k], vF[k]);
                pipeI[k] <= vI[k];
                pipeF[k] <= vF[k];
            end
        end
        if (done) doneCount <= doneCount + 1;
    end

    task automatic applyStimulus(input logic st, input logic [CW-1:0] ln,
                                 input logic iv, input logic fv,
                                 input logic [W-1:0] id, input logic [W-1:0] fd);
        @(negedge clk);
        start           = st;
        len             = ln;
        bus.imap_valid  = iv;
        bus.fmap_valid  = fv;
        bus.imap_data   = id;
        bus.fmap_data   = fd;
        #1;
    endtask

    task automatic holdCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.imap_valid = 1'b0;
        bus.fmap_valid = 1'b0;
        bus.imap_data  = '0;
        bus.fmap_data  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst imap_ready", bus.imap_ready, 0);
        checkOutput("rst fmap_ready", bus.fmap_ready, 0);
        checkOutput("rst pe_rst", bus.pe_rst, 0);
        checkOutput("rst pe_imap", bus.pe_imap, 0);
        checkOutput("rst pe_fmap", bus.pe_fmap, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic job: len=3, imap 1,2,3 times fmap 2
        applyStimulus(1, 3, 0, 0, 0, 0);
        checkOutput("t1 c0 busy", busy, 0);
        applyStimulus(0, 0, 1, 1, 1, 2);
        checkOutput("t1 c1 pe_rst", bus.pe_rst, 1);
        checkOutput("t1 c1 imap_ready", bus.imap_ready, 0);
        checkOutput("t1 c1 pe_imap", bus.pe_imap, 0);
        checkOutput("t1 c1 busy", busy, 1);
        applyStimulus(0, 0, 1, 1, 1, 2);
        checkOutput("t1 c2 imap_ready", bus.imap_ready, 1);
        checkOutput("t1 c2 fmap_ready", bus.fmap_ready, 1);
        checkOutput("t1 c2 pe_imap", bus.pe_imap, 1);
        checkOutput("t1 c2 pe_fmap", bus.pe_fmap, 2);
        checkOutput("t1 c2 pe_rst", bus.pe_rst, 0);
        applyStimulus(0, 0, 1, 1, 2, 2);
        checkOutput("t1 c3 pe_imap", bus.pe_imap, 2);
        applyStimulus(0, 0, 1, 1, 3, 2);
        checkOutput("t1 c4 pe_imap", bus.pe_imap, 3);
        checkOutput("t1 c4 imap_ready", bus.imap_ready, 1);
        applyStimulus(0, 0, 1, 1, 9, 9);
        checkOutput("t1 c5 imap_ready", bus.imap_ready, 0);
        checkOutput("t1 c5 pe_imap", bus.pe_imap, 0);
        for (int i = 6; i <= 8; i++) begin
            holdCycle();
            checkOutput("t1 flush done", done, 0);
        end
        holdCycle();
        checkOutput("t1 c9 done", done, 1);
        checkOutput("t1 c9 busy", busy, 1);
        holdCycle();
        checkOutput("t1 c10 done", done, 0);
        checkOutput("t1 c10 busy", busy, 0);
        checkOutput("t1 omap re", accRe[NPE-1], 16'd12);
        checkOutput("t1 omap im", accIm[NPE-1], 16'd0);
        checkOutput("t1 done pulses", doneCount, 1);

        // len=0: clear, flush only, no beats
        applyStimulus(1, 0, 1, 1, 9, 9);
        checkOutput("t2 c0 ready", bus.imap_ready, 0);
        applyStimulus(0, 0, 1, 1, 9, 9);
        checkOutput("t2 c1 pe_rst", bus.pe_rst, 1);
        checkOutput("t2 c1 ready", bus.imap_ready, 0);
        for (int i = 2; i <= 5; i++) begin
            holdCycle();
            checkOutput("t2 flush imap_ready", bus.imap_ready, 0);
            checkOutput("t2 flush fmap_ready", bus.fmap_ready, 0);
            checkOutput("t2 flush done", done, 0);
        end
        holdCycle();
        checkOutput("t2 c6 done", done, 1);
        holdCycle();
        checkOutput("t2 omap re", accRe[NPE-1], 16'd0);
        checkOutput("t2 busy", busy, 0);

        // Two-cycle fmap stall on the second beat
        applyStimulus(1, 3, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 2);
        holdCycle();
        checkOutput("t3 c2 pe_imap", bus.pe_imap, 1);
        applyStimulus(0, 0, 1, 0, 2, 2);
        checkOutput("t3 c3 imap_ready", bus.imap_ready, 0);
        checkOutput("t3 c3 fmap_ready", bus.fmap_ready, 0);
        checkOutput("t3 c3 pe_imap", bus.pe_imap, 0);
        checkOutput("t3 c3 pe_fmap", bus.pe_fmap, 0);
        holdCycle();
        checkOutput("t3 c4 imap_ready", bus.imap_ready, 0);
        checkOutput("t3 c4 pe_imap", bus.pe_imap, 0);
        applyStimulus(0, 0, 1, 1, 2, 2);
        checkOutput("t3 c5 ready", bus.imap_ready, 1);
        checkOutput("t3 c5 pe_imap", bus.pe_imap, 2);
        applyStimulus(0, 0, 1, 1, 3, 2);
        checkOutput("t3 c6 pe_imap", bus.pe_imap, 3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t3 c7 ready", bus.imap_ready, 0);
        for (int i = 8; i <= 10; i++) begin
            holdCycle();
            checkOutput("t3 flush done", done, 0);
        end
        holdCycle();
        checkOutput("t3 c11 done", done, 1);
        holdCycle();
        checkOutput("t3 omap re", accRe[NPE-1], 16'd12);

        // start pulsed mid-FEED must be neither taken nor queued
        doneBase = doneCount;
        applyStimulus(1, 3, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 2);
        holdCycle();
        applyStimulus(1, 7, 1, 1, 2, 2);
        checkOutput("t4 c3 pe_imap", bus.pe_imap, 2);
        applyStimulus(0, 0, 1, 1, 3, 2);
        checkOutput("t4 c4 pe_imap", bus.pe_imap, 3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 6; i <= 8; i++) begin
            holdCycle();
            checkOutput("t4 flush done", done, 0);
        end
        holdCycle();
        checkOutput("t4 c9 done", done, 1);
        holdCycle();
        checkOutput("t4 c10 busy", busy, 0);
        repeat (10) holdCycle();
        checkOutput("t4 later busy", busy, 0);
        checkOutput("t4 done pulses", doneCount - doneBase, 1);
        checkOutput("t4 omap re", accRe[NPE-1], 16'd12);

        // Reset during FEED, then a fresh len=2 job
        applyStimulus(1, 3, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 2);
        holdCycle();
        checkOutput("t5 c2 ready", bus.imap_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t5 rst busy", busy, 0);
        checkOutput("t5 rst imap_ready", bus.imap_ready, 0);
        checkOutput("t5 rst fmap_ready", bus.fmap_ready, 0);
        checkOutput("t5 rst pe_imap", bus.pe_imap, 0);
        checkOutput("t5 rst pe_rst", bus.pe_rst, 0);
        checkOutput("t5 rst done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t5 idle ready", bus.imap_ready, 0);
        applyStimulus(1, 2, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 5, 3);
        checkOutput("t5 c1 pe_rst", bus.pe_rst, 1);
        holdCycle();
        checkOutput("t5 c2 pe_imap", bus.pe_imap, 5);
        applyStimulus(0, 0, 1, 1, 6, 3);
        checkOutput("t5 c3 pe_imap", bus.pe_imap, 6);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 5; i <= 7; i++) begin
            holdCycle();
            checkOutput("t5 flush done", done, 0);
        end
        holdCycle();
        checkOutput("t5 c8 done", done, 1);
        holdCycle();
        checkOutput("t5 omap re", accRe[NPE-1], 16'd33);

        // Complex product (1+2j)(3+4j) = -5+10j
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 32'h0002_0001, 32'h0004_0003);
        holdCycle();
        checkOutput("t6 c2 pe_imap", bus.pe_imap, 32'h0002_0001);
        checkOutput("t6 c2 pe_fmap", bus.pe_fmap, 32'h0004_0003);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t6 c3 ready", bus.imap_ready, 0);
        for (int i = 4; i <= 6; i++) begin
            holdCycle();
            checkOutput("t6 flush done", done, 0);
        end
        holdCycle();
        checkOutput("t6 c7 done", done, 1);
        holdCycle();
        checkOutput("t6 omap re", accRe[NPE-1], 16'hFFFB);
        checkOutput("t6 omap im", accIm[NPE-1], 16'h000A);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pe_row_sched.md
PE_ROW_SCHED -- requirements
Module: pe_row_sched

Interface
REQ-001 Parameter IN_WORD_SIZE, default 32, packed complex word width: real in [15:0], imag in [31:16].
REQ-002 Parameter NUM_PE, default 8, number of chained PEs in the row (range 1..255).
REQ-003 Parameter CNT_W, default 16, width of the beat-count field.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  request a new accumulation job; sampled only in IDLE.
REQ-007 len  in  CNT_W  number of operand beats in the job; captured when start is accepted.
REQ-008 imap_valid / imap_data  in  1 / IN_WORD_SIZE  input-map operand stream.
REQ-009 imap_ready  out  1  operand consumed this cycle.
REQ-010 fmap_valid / fmap_data  in  1 / IN_WORD_SIZE  filter operand stream.
REQ-011 fmap_ready  out  1  operand consumed this cycle.
REQ-012 pe_rst  out  1  synchronous clear to the PE row (zeroes omap and the forwarded operands).
REQ-013 pe_imap / pe_fmap  out  IN_WORD_SIZE  operands driven into the first PE.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse: all PE omap values are final.

Function
REQ-016 FSM states are IDLE, CLEAR, FEED, FLUSH and DONE.
REQ-017 IDLE->CLEAR on start=1; len is latched into the beat counter in that cycle.
REQ-018 CLEAR lasts exactly 1 cycle with pe_rst=1; it then goes to FEED if latched len>0, else to FLUSH.
REQ-019 A FEED beat fires when imap_valid & fmap_valid; imap_ready = fmap_ready = that AND, so both streams are consumed together or not at all.
REQ-020 On a fired beat, pe_imap/pe_fmap equal imap_data/fmap_data in the same cycle (combinational pass-through) and the beat counter decrements.
REQ-021 On a stalled FEED cycle, and in every non-FEED state, pe_imap and pe_fmap are driven to 0, so the PE adds a zero product.
REQ-022 FEED->FLUSH on the cycle the final beat fires (counter==1 and fire).
REQ-023 FLUSH lasts exactly NUM_PE cycles, counted by a flush counter; it then goes to DONE.
REQ-024 DONE lasts 1 cycle with done=1, then returns to IDLE.
REQ-025 Ready outputs are 0 outside FEED; pe_rst is 0 outside CLEAR.
REQ-026 start while busy is ignored and is not queued.
REQ-027 Minimum job latency, from start accepted to done, is 1 + len + NUM_PE + 1 cycles with no stalls; each stall adds 1 cycle.
REQ-028 len = 2^CNT_W-1 is legal; the counter does not wrap.

Reset
REQ-029 Asserting rst at any time forces IDLE immediately, with both counters = 0, pe_rst=0, all ready outputs 0, busy=0 and done=0.
REQ-030 pe_imap/pe_fmap read 0 during reset; an interrupted job is discarded, and the next start performs a fresh CLEAR.

Structure
REQ-031 The state encoding and the default values of IN_WORD_SIZE and NUM_PE belong in the shared package pe_pkg.
REQ-032 The block is a single module with no sub-modules; the PE row is instantiated by the parent.

Verification
REQ-033 NUM_PE=4, len=3, both streams always valid, real operands 1,2,3 with 2 on both streams -> pe_rst at cycle 1, beats at cycles 2-4, done at cycle 9, last PE real omap = 12.
REQ-034 len=0 -> CLEAR, then 4 FLUSH cycles, then done; ready outputs never asserted; omap = 0.
REQ-035 fmap_valid low on the 2nd beat for 2 cycles, imap always valid -> neither ready asserts during the stall, pe operands are 0, done is delayed by 2 cycles, result is unchanged.
REQ-036 start pulsed during FEED -> ignored; only one done pulse.
REQ-037 rst asserted mid-FEED -> busy=0 and all ready outputs 0 immediately; a subsequent job with len=2 produces the correct, uncorrupted sum.
REQ-038 Complex check: imap=(1+2j), fmap=(3+4j), len=1 -> final omap real = 0xFFFB (-5), imag = 10.
